// File: rtl/led_bnc_arbiter_if.sv
// Display-sharing bus between status requesters and the LED/BNC arbiter.
// The arbiter takes the slave side; the requesters take the master side.
interface led_bnc_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] pat;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic              tick;
    logic [3:0]        leds;
    logic [3:0]        bnc;
    logic [3:0]        gnd;

    modport master (
        output req, pat,
        input  gnt, done, busy, tick, leds, bnc, gnd
    );

    modport slave (
        input  req, pat,
        output gnt, done, busy, tick, leds, bnc, gnd
    );
endinterface

// File: rtl/led_bnc_arbiter.sv
// Round-robin arbiter sharing the front-panel LEDs and BNC monitor outputs
// among NREQ status requesters. A granted 4-bit pattern is shown for
// HOLD_TICKS prescaler ticks; when idle, a 4-bit heartbeat counter is shown.
// Both output banks are active-low copies of the displayed value.
module led_bnc_arbiter #(
    parameter int NREQ       = 4,
    parameter int TICK_DIV   = 200000000,
    parameter int HOLD_TICKS = 2
) (
    input logic              clk,
    input logic              rst_in,
    led_bnc_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [IW-1:0] LAST_INIT  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_REL
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   presc_q;
    logic            tick_q;
    logic [3:0]      hb_q;
    logic [3:0]      disp_q;
    logic [HW-1:0]   hold_q;
    logic [IW-1:0]   last_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;

    logic            tick_evt;
    logic            owner_req;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [3:0]      win_pat;

    // Pick the first set request at or after (last+1) mod NREQ, wrapping.
    // The candidate with the smallest forward distance from last+1 wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   l);
        logic [IW-1:0] w;
        int            best_d;
        int            d;
        w      = l;
        best_d = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(l) - 1 + 2 * NREQ) % NREQ;
            if (r[i] && (d < best_d)) begin
                best_d = d;
                w      = IW'(i);
            end
        end
        return w;
    endfunction

    // The tick event fires on the last prescaler count; the registered tick
    // output and every tick-driven counter update on the same edge.
    assign tick_evt  = (presc_q == PRESC_LAST);
    assign win_idx   = rr_pick(bus.req, last_q);
    // The owner still wants the display as long as its request is high.
    assign owner_req = |(bus.req & gnt_q);

    // Decode the winner into a one-hot grant and select its pattern.
    always_comb begin
        win_oh  = '0;
        win_pat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(win_idx) == i) begin
                win_oh[i] = 1'b1;
                win_pat   = bus.pat[4*i +: 4];
            end
        end
    end

    // Control FSM with prescaler, heartbeat, hold counter and display register.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            hb_q    <= '0;
            disp_q  <= '0;
            hold_q  <= '0;
            last_q  <= LAST_INIT;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= '0;
            tick_q <= tick_evt;
            if (tick_evt) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        // Restart the prescaler so the hold spans exactly
                        // HOLD_TICKS*TICK_DIV cycles; no tick this cycle.
                        state_q <= ST_SHOW;
                        presc_q <= '0;
                        tick_q  <= 1'b0;
                        gnt_q   <= win_oh;
                        busy_q  <= 1'b1;
                        disp_q  <= win_pat;
                        hold_q  <= '0;
                        last_q  <= win_idx;
                    end else if (tick_evt) begin
                        hb_q   <= hb_q + 4'd1;
                        disp_q <= hb_q + 4'd1;
                    end else begin
                        disp_q <= hb_q;
                    end
                end
                ST_SHOW: begin
                    if (!owner_req) begin
                        // Abort wins over a completion landing on the same cycle.
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        disp_q  <= hb_q;
                    end else if (tick_evt) begin
                        hold_q <= hold_q + 1'b1;
                        if (hold_q == HOLD_LAST) begin
                            state_q <= ST_REL;
                            done_q  <= gnt_q;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            disp_q  <= hb_q;
                        end
                    end
                end
                ST_REL: begin
                    state_q <= ST_IDLE;
                    disp_q  <= hb_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.tick = tick_q;
    assign bus.leds = ~disp_q;
    assign bus.bnc  = ~disp_q;
    assign bus.gnd  = 4'hF;

endmodule

// File: doc/led_bnc_arbiter.md
Name: led_bnc_arbiter

Overview:
Shares the front-panel LED bank and the BNC monitor outputs among NREQ status requesters. A granted requester's 4-bit pattern is held on the display for a fixed number of prescaler ticks. With no request pending, a free-running heartbeat counter is displayed. Sits between firmware status sources and the board output pins, replacing the stand-alone LED counter; contains its own tick prescaler.

Parameters:
NREQ, 4, number of requesters (2..8)
TICK_DIV, 200000000, clk cycles per tick (≥2); 1 Hz at 200 MHz
HOLD_TICKS, 2, ticks a granted pattern is displayed (≥1)

Ports:
clk  input  1  system clock
rst_in  input  1  asynchronous reset, active-low
req  input  NREQ  per-requester display request, level, held until done or abort
pat  input  4*NREQ  requester i pattern in pat[4i+3:4i], active-high
gnt  output  NREQ  one-hot, high while requester i owns the display
done  output  NREQ  one-cycle pulse, requester i hold completed
busy  output  1  high in SHOW
tick  output  1  one-cycle prescaler pulse
leds  output  4  LED drive, active-low (~disp)
bnc  output  4  BNC drive, active-low (~disp)
gnd  output  4  constant 4'hF

Behaviour:
- Reset (rst_in low, async): state=IDLE, disp=0 (leds=bnc=4'hF), gnt=0, done=0, busy=0, tick=0, prescaler=0, heartbeat=0, hold_cnt=0, last=NREQ-1 (requester 0 wins first). gnd=4'hF always, including in reset.
- All outputs registered.
- Prescaler: counts 0..TICK_DIV-1; tick=1 for the cycle after count==TICK_DIV-1, then wraps to 0. Forced to 0 (no tick) on the cycle a grant is issued, so the hold lasts exactly HOLD_TICKS*TICK_DIV cycles.
- Heartbeat: 4-bit counter, +1 on each tick in IDLE only. Wraps F→0. Holds its value during SHOW/RELEASE and resumes afterwards.
- States:
  - IDLE: disp=heartbeat.
    - If any req: winner = first set req scanning from (last+1) mod NREQ upward with wrap.
    - Next cycle: state=SHOW, gnt[winner]=1, busy=1, disp=pat[winner] (captured once; later pat changes ignored), hold_cnt=0, last=winner.
    - Latency req→gnt/leds: 1 cycle.
  - SHOW: hold_cnt increments on tick.
    - When a tick brings hold_cnt to HOLD_TICKS: next cycle done[winner]=1 for 1 cycle, gnt=0, busy=0, state=RELEASE.
    - Abort: if req[winner] drops during SHOW, next cycle gnt=0, busy=0, state=IDLE, no done pulse, disp=heartbeat.
    - Abort takes precedence over completion in the same cycle.
  - RELEASE: exactly 1 cycle. disp=heartbeat, no arbitration. Then IDLE.
- After done, a requester is expected to drop req. If req is still high in IDLE it re-enters arbitration normally; round-robin ensures other pending requesters are served first.
- Requests from other requesters during SHOW are ignored; they are evaluated in the next IDLE.
- Reset asserted mid-SHOW: immediate return to reset values; no done pulse is generated.

Test Plan:
1. Reset, TICK_DIV=4, HOLD_TICKS=2, no req → leds=bnc=4'hF, gnd=4'hF. tick every 4 cycles; after 3 ticks leds=~3=4'hC.
2. req[2]=1, pat[2]=4'b1010 in IDLE → next cycle gnt=4'b0100, busy=1, leds=4'b0101. Exactly 8 cycles later done[2] pulses 1 cycle, gnt=0. Heartbeat unchanged across the hold.
3. req=4'b1111, each held until its own done then dropped → grants in order 0,1,2,3. Each SHOW is separated by one RELEASE and one IDLE cycle.
4. After requester 1 is served, req[1] and req[3] both high → requester 3 granted first (round-robin), then 1.
5. req[0] granted, dropped after 3 cycles of SHOW → gnt=0 next cycle, done stays 0, leds return to ~heartbeat.
6. rst_in pulsed low mid-SHOW → same cycle gnt=0, busy=0, leds=4'hF. No done pulse. After release, requester 0 has priority again.
